fire_logger: RTL
================

# fire_logger

Downstream consumer of the assertion checkers' `fire` vectors. It timestamps every cycle in which any fire bit is asserted and queues these events in a small FIFO for a testbench or debug reader to drain over a valid/ready port. It also keeps per-bit saturating event counts, sticky flags and the timestamp of the first failure, so a simulation or FPGA run can report the counter-overflow check result without a waveform dump.

## Interface
Parameters:
- `FIRE_WIDTH`, 3: width of the checker fire vector. Bit 0 is the assertion fail, bit 1 is the X-check fail, bit 2 is cover.
- `TS_WIDTH`, 16: width of the free-running timestamp.
- `CNT_WIDTH`, 8: width of each per-bit event counter.
- `DEPTH`, 4: number of event FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when low, fire is ignored and the timestamp freezes.
- `clr`, in, 1: synchronous clear of all state.
- `fire`, in, FIRE_WIDTH: fire vector from a checker.
- `rd_valid`, out, 1: FIFO head is valid.
- `rd_ready`, in, 1: reader accepts the head entry.
- `rd_fire`, out, FIRE_WIDTH: fire vector of the head entry.
- `rd_ts`, out, TS_WIDTH: timestamp of the head entry.
- `evt_cnt`, out, FIRE_WIDTH*CNT_WIDTH: per-bit counts; bit i occupies `[i*CNT_WIDTH +: CNT_WIDTH]`.
- `sticky`, out, FIRE_WIDTH: OR of all fire bits seen since the last reset or clear.
- `first_vld`, out, 1: `first_ts` holds a captured value.
- `first_ts`, out, TS_WIDTH: timestamp of the first event with fire bit 0 set.
- `overrun`, out, 1: sticky flag; at least one event was dropped because the FIFO was full.

## Operation
- **Reset:** the asynchronous active-low reset zeroes every register. All outputs are 0 during and after reset, including `rd_valid`, `rd_fire`, `rd_ts`, `evt_cnt`, `sticky`, `first_vld`, `first_ts` and `overrun`.
- **Timestamp:** `ts` increments by 1 each cycle that `enable` is high. It wraps from all-ones to 0 with no flag.
- **Event:** an event occurs in a cycle where `enable` is high and `fire` is non-zero.
  - The pair {fire, ts}, using the pre-increment `ts`, is pushed into the FIFO.
  - For each set fire bit, `evt_cnt[i]` increments, saturating at all-ones.
  - For each set fire bit, `sticky[i]` is set.
- **First failure:** the first event with fire bit 0 set while `first_vld` is 0 captures `first_ts` and sets `first_vld`. Later fail events do not change these.
- **Full FIFO:** an event arriving when the FIFO is full is dropped and sets `overrun`. Counters and sticky bits still update.
- **Full FIFO with pop:** if a pop happens in the same cycle as a push to a full FIFO, the push is accepted and no overrun is flagged.
- **Empty FIFO:** a push into an empty FIFO gives `rd_valid` = 1 on the next cycle. There is no fall-through.
- **Read port:**
  - A pop occurs when `rd_valid` and `rd_ready` are both high.
  - `rd_fire` and `rd_ts` show the head entry and are 0 when the FIFO is empty.
  - `rd_ready` while empty has no effect.
- **Clear:** `clr` has priority over everything else in its cycle.
  - It flushes the FIFO and zeroes `ts`, counters, `sticky`, `first_*` and `overrun`.
  - An event in the same cycle is discarded.
- **Enable low:** `fire` is ignored, but reads continue.

## Timing
- Latency from fire sampled at edge N to visibility:
  - `rd_valid` and FIFO outputs are valid after edge N, if the FIFO was empty.
  - `evt_cnt`, `sticky` and `first_*` are valid after edge N.
- Event throughput is 1 per cycle. The read port sustains 1 pop per cycle.
- The head updates on the edge after a pop. With back-to-back entries, `rd_valid` stays high.
- The FIFO uses pointers of width log2(DEPTH)+1; full means the MSBs differ and the other bits match.
- `rst_n` asserted mid-operation clears state immediately, asynchronously. Deassertion is assumed synchronised externally.

## Structure
- Package `fire_logger_pkg` holds:
  - default parameter constants;
  - the entry struct `{fire, ts}`;
  - the fire-bit index constants `FIRE_ASSERT`=0, `FIRE_XCHECK`=1, `FIRE_COVER`=2.
- One sub-module, `fire_logger_fifo`: a parameterised synchronous FIFO with push, pop, full, empty and flush. The top level holds the timestamp, counters, sticky flags and first-capture logic.

## Test plan
- Reset, then 10 cycles idle with `enable`=1 → all outputs 0, internal `ts`=10; after reset mid-run, all outputs 0 at once.
- `fire`=3'b001 at ts=5, `rd_ready`=0 → the next cycle shows `rd_valid`=1, `rd_fire`=001, `rd_ts`=5, `first_vld`=1, `first_ts`=5, `evt_cnt[0]`=1, `sticky`=001.
- 5 consecutive events with `rd_ready`=0 and DEPTH=4 → 4 entries queued, `overrun`=1, `evt_cnt[0]`=5. Then drain with `rd_ready`=1 → 4 entries with ascending ts, then `rd_valid`=0.
- FIFO full, event plus pop in the same cycle → `overrun` stays 0 and the occupancy stays 4.
- 300 events with `fire`=3'b100 and continuous reads, CNT_WIDTH=8 → `evt_cnt[2]`=255, `first_vld`=0.
- `clr` asserted together with `fire`=001 → everything 0 next cycle and the event is not logged. Separately, `enable`=0 with `fire`=111 → no change.

Source files
------------

// File: rtl/fire_logger_pkg.sv
// Shared constants and types for the fire logger.
package fire_logger_pkg;
  localparam int DEF_FIRE_WIDTH = 3;
  localparam int DEF_TS_WIDTH   = 16;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_DEPTH      = 4;

  // Fire-bit meanings.
  localparam int FIRE_ASSERT = 0;
  localparam int FIRE_XCHECK = 1;
  localparam int FIRE_COVER  = 2;

  // One logged event at the default widths.
  typedef struct packed {
    logic [DEF_FIRE_WIDTH-1:0] fire;
    logic [DEF_TS_WIDTH-1:0]   ts;
  } entry_t;
endpackage

// File: rtl/fire_logger_fifo.sv
// Registered-output synchronous FIFO with flush; head reads 0 when empty.
module fire_logger_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wptr, rptr;
  logic                    do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head is leaving this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer and storage update; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= din;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/fire_logger.sv
// Timestamps checker fire events, queues them and keeps per-bit statistics.
module fire_logger
  import fire_logger_pkg::*;
#(
  parameter int FIRE_WIDTH = DEF_FIRE_WIDTH,
  parameter int TS_WIDTH   = DEF_TS_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clr,
  input  logic [FIRE_WIDTH-1:0]           fire,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [FIRE_WIDTH-1:0]           rd_fire,
  output logic [TS_WIDTH-1:0]             rd_ts,
  output logic [FIRE_WIDTH*CNT_WIDTH-1:0] evt_cnt,
  output logic [FIRE_WIDTH-1:0]           sticky,
  output logic                            first_vld,
  output logic [TS_WIDTH-1:0]             first_ts,
  output logic                            overrun
);
  localparam int EW = FIRE_WIDTH + TS_WIDTH;

  logic [TS_WIDTH-1:0] ts;
  logic                evt, pop, full, empty, push;
  logic [EW-1:0]       head;

  assign evt      = enable && (|fire);
  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign push     = evt && !clr;
  assign rd_fire  = head[EW-1:TS_WIDTH];
  assign rd_ts    = head[TS_WIDTH-1:0];

  fire_logger_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push),
    .pop   (pop),
    .din   ({fire, ts}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Free-running timestamp, frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts <= '0;
    else if (clr)    ts <= '0;
    else if (enable) ts <= ts + 1'b1;
  end

  // Per-bit saturating event counters.
  for (genvar i = 0; i < FIRE_WIDTH; i++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt;
    // Count events on this bit, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              cnt <= '0;
      else if (clr)                            cnt <= '0;
      else if (evt && fire[i] && (cnt != '1))  cnt <= cnt + 1'b1;
    end
    assign evt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
  end

  // Sticky OR of every fire bit seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   sticky <= '0;
    else if (clr) sticky <= '0;
    else if (evt) sticky <= sticky | fire;
  end

  // Capture the timestamp of the first assertion failure only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_vld <= 1'b0;
      first_ts  <= '0;
    end else if (clr) begin
      first_vld <= 1'b0;
      first_ts  <= '0;
    end else if (evt && fire[FIRE_ASSERT] && !first_vld) begin
      first_vld <= 1'b1;
      first_ts  <= ts;
    end
  end

  // Flag any event lost to a full FIFO that was not draining that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overrun <= 1'b0;
    else if (clr)                    overrun <= 1'b0;
    else if (evt && full && !pop)    overrun <= 1'b1;
  end
endmodule
